// File: rtl/dbi_rx_decoder.sv
// dbi_rx_decoder: MIPI DBI Type-B (8080, 8-bit) panel-side receiver used as loopback/self-test model.
// clk, rst_n                      : internal clock, asynchronous active-low reset
// dbi_resx_i/csx_i/dcx_i/wrx_i/d_i : asynchronous DBI bus pins, synchronised here
// pxl_d_o/x_o/y_o, pxl_vld_o      : assembled RGB565 pixel with its coordinate, one-cycle strobe
// frm_done_o                      : strobe with the last pixel of the address window
// disp_on_o, soft_rst_o           : display-on state, soft-reset pulse
// cmd_o, cmd_vld_o                : last command byte and its one-cycle strobe
module dbi_rx_decoder #(
    parameter int                    DBI_IF_D_W    = 8,
    parameter int                    PXL_W         = 16,
    parameter int                    SYNC_STAGES   = 2,
    parameter logic [DBI_IF_D_W-1:0] ADDR_SOFT_RST = 8'h01,
    parameter logic [DBI_IF_D_W-1:0] ADDR_DISP_OFF = 8'h28,
    parameter logic [DBI_IF_D_W-1:0] ADDR_DISP_ON  = 8'h29,
    parameter logic [DBI_IF_D_W-1:0] ADDR_COL      = 8'h2A,
    parameter logic [DBI_IF_D_W-1:0] ADDR_ROW      = 8'h2B,
    parameter logic [DBI_IF_D_W-1:0] ADDR_MEM_WR   = 8'h2C,
    parameter logic [15:0]           COL_DEF_E     = 16'd319,
    parameter logic [15:0]           ROW_DEF_E     = 16'd239
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dbi_resx_i,
    input  logic                  dbi_csx_i,
    input  logic                  dbi_dcx_i,
    input  logic                  dbi_wrx_i,
    input  logic [DBI_IF_D_W-1:0] dbi_d_i,
    output logic [PXL_W-1:0]      pxl_d_o,
    output logic [15:0]           pxl_x_o,
    output logic [15:0]           pxl_y_o,
    output logic                  pxl_vld_o,
    output logic                  frm_done_o,
    output logic                  disp_on_o,
    output logic                  soft_rst_o,
    output logic [DBI_IF_D_W-1:0] cmd_o,
    output logic                  cmd_vld_o
);
    localparam int W  = DBI_IF_D_W;
    localparam int SW = W + 4;
    // Idle bus levels: resx/csx/wrx high so reset release never looks like an edge.
    localparam logic [SW-1:0] SYNC_IDLE = {1'b1, 1'b1, 1'b0, 1'b1, {W{1'b0}}};
    typedef enum logic [1:0] {CMD_ST, COL_ST, ROW_ST, MEM_ST} state_t;
    logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
    logic [SW-1:0]  s;
    logic           s_resx, s_csx, s_dcx, s_wrx, byte_stb, win_rst;
    logic [W-1:0]   s_d;
    state_t         state_q, state_d;
    logic [1:0]     idx_q, idx_d;
    logic [3*W-1:0] tmp_q, tmp_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [15:0]    cs_q, cs_d, ce_q, ce_d, rs_q, rs_d, re_q, re_d, x_q, x_d, y_q, y_d;
    logic           wrx_prev_q, wrx_prev_d, resx_prev_q, resx_prev_d, disp_on_q, disp_on_d;
    logic [PXL_W-1:0] pxl_d_q, pxl_d_d;
    logic [15:0]    pxl_x_q, pxl_x_d, pxl_y_q, pxl_y_d;
    logic           pxl_vld_q, pxl_vld_d, frm_done_q, frm_done_d, soft_rst_q, soft_rst_d, cmd_vld_q, cmd_vld_d;
    logic [W-1:0]   cmd_q, cmd_d;

    assign s        = sync_q[SYNC_STAGES-1];
    assign s_resx   = s[W+3];
    assign s_csx    = s[W+2];
    assign s_dcx    = s[W+1];
    assign s_wrx    = s[W];
    assign s_d      = s[W-1:0];
    assign byte_stb = s_wrx & ~wrx_prev_q & ~s_csx;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], dbi_resx_i, dbi_csx_i, dbi_dcx_i, dbi_wrx_i, dbi_d_i};
        wrx_prev_d  = s_wrx;
        resx_prev_d = s_resx;
        state_d     = state_q;
        idx_d       = idx_q;
        tmp_d       = tmp_q;
        hi_d        = hi_q;
        cs_d        = cs_q;
        ce_d        = ce_q;
        rs_d        = rs_q;
        re_d        = re_q;
        x_d         = x_q;
        y_d         = y_q;
        disp_on_d   = disp_on_q;
        pxl_d_d     = pxl_d_q;
        pxl_x_d     = pxl_x_q;
        pxl_y_d     = pxl_y_q;
        pxl_vld_d   = 1'b0;
        frm_done_d  = 1'b0;
        soft_rst_d  = 1'b0;
        cmd_d       = cmd_q;
        cmd_vld_d   = 1'b0;
        win_rst     = 1'b0;
        if (!s_resx) begin
            // Held in soft reset; pulse only on the falling edge.
            win_rst    = 1'b1;
            soft_rst_d = resx_prev_q;
        end else if (s_csx) begin
            state_d = CMD_ST;
            idx_d   = '0;
        end else if (byte_stb && !s_dcx) begin
            cmd_d     = s_d;
            cmd_vld_d = 1'b1;
            idx_d     = '0;
            state_d   = s_d == ADDR_COL ? COL_ST : s_d == ADDR_ROW ? ROW_ST : s_d == ADDR_MEM_WR ? MEM_ST : CMD_ST;
            x_d       = cs_q;
            y_d       = rs_q;
            disp_on_d = s_d == ADDR_DISP_ON ? 1'b1 : s_d == ADDR_DISP_OFF ? 1'b0 : disp_on_q;
            win_rst    = s_d == ADDR_SOFT_RST;
            soft_rst_d = s_d == ADDR_SOFT_RST;
        end else if (byte_stb && (state_q == COL_ST || state_q == ROW_ST)) begin
            if (idx_q != 2'd3) begin
                tmp_d = {tmp_q[2*W-1:0], s_d};
                idx_d = idx_q + 2'd1;
            end else begin
                // Window only changes once all four bytes are in.
                idx_d   = '0;
                state_d = CMD_ST;
                cs_d    = state_q == COL_ST ? 16'(tmp_q[3*W-1:W]) : cs_q;
                ce_d    = state_q == COL_ST ? 16'({tmp_q[W-1:0], s_d}) : ce_q;
                rs_d    = state_q == ROW_ST ? 16'(tmp_q[3*W-1:W]) : rs_q;
                re_d    = state_q == ROW_ST ? 16'({tmp_q[W-1:0], s_d}) : re_q;
            end
        end else if (byte_stb && state_q == MEM_ST) begin
            if (!idx_q[0]) begin
                hi_d  = s_d;
                idx_d = 2'd1;
            end else begin
                idx_d      = '0;
                pxl_d_d    = PXL_W'({hi_q, s_d});
                pxl_x_d    = x_q;
                pxl_y_d    = y_q;
                pxl_vld_d  = 1'b1;
                frm_done_d = x_q == ce_q && y_q == re_q;
                x_d        = x_q == ce_q ? cs_q : x_q + 16'd1;
                y_d        = x_q != ce_q ? y_q : y_q == re_q ? rs_q : y_q + 16'd1;
            end
        end
        if (win_rst) begin
            state_d   = CMD_ST;
            idx_d     = '0;
            cs_d      = '0;
            ce_d      = COL_DEF_E;
            rs_d      = '0;
            re_d      = ROW_DEF_E;
            disp_on_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= {SYNC_STAGES{SYNC_IDLE}};
            wrx_prev_q  <= 1'b1;
            resx_prev_q <= 1'b1;
            state_q     <= CMD_ST;
            idx_q       <= '0;
            tmp_q       <= '0;
            hi_q        <= '0;
            cs_q        <= '0;
            ce_q        <= COL_DEF_E;
            rs_q        <= '0;
            re_q        <= ROW_DEF_E;
            x_q         <= '0;
            y_q         <= '0;
            disp_on_q   <= 1'b0;
            pxl_d_q     <= '0;
            pxl_x_q     <= '0;
            pxl_y_q     <= '0;
            pxl_vld_q   <= 1'b0;
            frm_done_q  <= 1'b0;
            soft_rst_q  <= 1'b0;
            cmd_q       <= '0;
            cmd_vld_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            wrx_prev_q  <= wrx_prev_d;
            resx_prev_q <= resx_prev_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmp_q       <= tmp_d;
            hi_q        <= hi_d;
            cs_q        <= cs_d;
            ce_q        <= ce_d;
            rs_q        <= rs_d;
            re_q        <= re_d;
            x_q         <= x_d;
            y_q         <= y_d;
            disp_on_q   <= disp_on_d;
            pxl_d_q     <= pxl_d_d;
            pxl_x_q     <= pxl_x_d;
            pxl_y_q     <= pxl_y_d;
            pxl_vld_q   <= pxl_vld_d;
            frm_done_q  <= frm_done_d;
            soft_rst_q  <= soft_rst_d;
            cmd_q       <= cmd_d;
            cmd_vld_q   <= cmd_vld_d;
        end
    end

    assign pxl_d_o    = pxl_d_q;
    assign pxl_x_o    = pxl_x_q;
    assign pxl_y_o    = pxl_y_q;
    assign pxl_vld_o  = pxl_vld_q;
    assign frm_done_o = frm_done_q;
    assign disp_on_o  = disp_on_q;
    assign soft_rst_o = soft_rst_q;
    assign cmd_o      = cmd_q;
    assign cmd_vld_o  = cmd_vld_q;
endmodule

// File: tb/tb_dbi_rx_decoder.sv
// tb_dbi_rx_decoder: randomized bench for dbi_rx_decoder against a byte-level panel model.
module tb_dbi_rx_decoder;
    logic        clk, rst_n, resx, csx, dcx, wrx;
    logic [7:0]  d;
    logic [15:0] pxl_d_o, pxl_x_o, pxl_y_o;
    logic        pxl_vld_o, frm_done_o, disp_on_o, soft_rst_o, cmd_vld_o;
    logic [7:0]  cmd_o;

    dbi_rx_decoder dut (
        .clk(clk), .rst_n(rst_n), .dbi_resx_i(resx), .dbi_csx_i(csx), .dbi_dcx_i(dcx),
        .dbi_wrx_i(wrx), .dbi_d_i(d), .pxl_d_o(pxl_d_o), .pxl_x_o(pxl_x_o), .pxl_y_o(pxl_y_o),
        .pxl_vld_o(pxl_vld_o), .frm_done_o(frm_done_o), .disp_on_o(disp_on_o),
        .soft_rst_o(soft_rst_o), .cmd_o(cmd_o), .cmd_vld_o(cmd_vld_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0, n_err = 0, soft_obs = 0, pxl_obs = 0, frm_obs = 0;
    logic [15:0] last_d, last_x, last_y;
    logic [48:0] exp_pxl[$];
    logic [7:0]  exp_cmd[$];
    logic [48:0] e_p;
    logic [7:0]  e_c;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Panel model: mode 0=command, 1=column params, 2=row params, 3=memory write.
    int          m_mode, m_idx, m_half, m_soft;
    logic        m_disp;
    logic [7:0]  m_par[4], m_hi;
    logic [15:0] m_cs, m_ce, m_rs, m_re, m_x, m_y;

    task automatic mdl_rst();
        m_soft++;
        m_cs = 0; m_ce = 319; m_rs = 0; m_re = 239;
        m_disp = 0; m_mode = 0; m_idx = 0; m_half = 0;
    endtask

    task automatic mdl_byte(input logic dc, input logic [7:0] b);
        if (!dc) begin
            exp_cmd.push_back(b);
            m_idx = 0; m_half = 0; m_mode = 0;
            case (b)
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin m_mode = 3; m_x = m_cs; m_y = m_rs; end
                8'h29: m_disp = 1;
                8'h28: m_disp = 0;
                8'h01: mdl_rst();
                default: ;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            m_par[m_idx] = b;
            m_idx++;
            if (m_idx == 4) begin
                if (m_mode == 1) begin m_cs = {m_par[0], m_par[1]}; m_ce = {m_par[2], m_par[3]}; end
                else begin m_rs = {m_par[0], m_par[1]}; m_re = {m_par[2], m_par[3]}; end
                m_mode = 0; m_idx = 0;
            end
        end else if (m_mode == 3) begin
            if (m_half == 0) begin
                m_hi = b; m_half = 1;
            end else begin
                exp_pxl.push_back({m_x == m_ce && m_y == m_re, m_hi, b, m_x, m_y});
                if (m_x == m_ce) begin
                    m_x = m_cs;
                    m_y = (m_y == m_re) ? m_rs : m_y + 1;
                end else m_x = m_x + 1;
                m_half = 0;
            end
        end
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        mdl_byte(dc, b);
        @(posedge clk); #2;
        dcx = dc; d = b; wrx = 0;
        repeat (4) @(posedge clk);
        #2 wrx = 1;
        repeat (4) @(posedge clk);
    endtask

    task automatic cmd(input logic [7:0] b); send(0, b); endtask
    task automatic px(input logic [15:0] v); send(1, v[15:8]); send(1, v[7:0]); endtask
    task automatic win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
        cmd(c); send(1, s[15:8]); send(1, s[7:0]); send(1, e[15:8]); send(1, e[7:0]);
    endtask

    task automatic set_cs(input logic v);
        if (v) begin m_mode = 0; m_idx = 0; m_half = 0; end
        @(posedge clk); #2 csx = v;
        repeat (4) @(posedge clk);
    endtask

    task automatic resx_pulse();
        mdl_rst();
        @(posedge clk); #2 resx = 0;
        repeat (6) @(posedge clk);
        #2 resx = 1;
        repeat (6) @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (pxl_vld_o) begin
                pxl_obs++;
                if (frm_done_o) frm_obs++;
                last_d = pxl_d_o; last_x = pxl_x_o; last_y = pxl_y_o;
                if (exp_pxl.size() == 0) chk("pxl_unexp", pxl_vld_o, 0);
                else begin
                    e_p = exp_pxl.pop_front();
                    chk("pxl{done,d,x,y}", {frm_done_o, pxl_d_o, pxl_x_o, pxl_y_o}, e_p);
                end
            end else chk("frm_no_vld", frm_done_o, 0);
            if (cmd_vld_o) begin
                if (exp_cmd.size() == 0) chk("cmd_unexp", cmd_vld_o, 0);
                else begin
                    e_c = exp_cmd.pop_front();
                    chk("cmd", cmd_o, e_c);
                end
            end
            if (soft_rst_o) soft_obs++;
        end
    end

    int f0, p0, s0, n;
    logic [7:0] c;
    logic [7:0] cl[8] = '{8'h01, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2C, 8'h00};

    initial begin
        resx = 1; csx = 1; dcx = 1; wrx = 1; d = 0; rst_n = 0;
        m_soft = 0; mdl_rst(); m_soft = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", pxl_vld_o, 0);
        chk("rst_frm", frm_done_o, 0);
        chk("rst_disp", disp_on_o, 0);
        chk("rst_soft", soft_rst_o, 0);
        chk("rst_cmd_vld", cmd_vld_o, 0);
        chk("rst_cmd", cmd_o, 0);
        chk("rst_pxl", {pxl_d_o, pxl_x_o, pxl_y_o}, 0);
        @(posedge clk); #2 rst_n = 1;
        repeat (4) @(posedge clk);
        chk("post_rst_soft", soft_obs, 0);
        resx_pulse();
        chk("resx_soft", soft_obs, 1);
        chk("resx_disp", disp_on_o, 0);
        chk("resx_no_pxl", pxl_obs, 0);
        set_cs(0);
        cmd(8'h29);
        chk("disp_on", disp_on_o, 1);
        cmd(8'h2C);
        for (int i = 0; i < 330; i++) begin
            px(16'(i));
            if (i == 0) chk("first_xy", {last_x, last_y}, {16'd0, 16'd0});
            if (i == 319) chk("row0_end", {last_x, last_y}, {16'd319, 16'd0});
            if (i == 320) chk("pix320_xy", {last_x, last_y}, {16'd0, 16'd1});
        end
        win(8'h2B, 16'd238, 16'd239);
        cmd(8'h2C);
        f0 = frm_obs;
        for (int i = 0; i < 645; i++) begin
            px(16'($urandom));
            if (i == 639) chk("frame_end_xy", {last_x, last_y}, {16'd319, 16'd239});
        end
        chk("frame_done_once", frm_obs - f0, 1);
        chk("disp_kept", disp_on_o, 1);
        win(8'h2A, 16'd10, 16'd11);
        win(8'h2B, 16'd5, 16'd6);
        cmd(8'h2C);
        f0 = frm_obs;
        for (int i = 0; i < 10; i++) begin
            px(16'($urandom));
            if (i == 3) chk("small_last", {last_x, last_y}, {16'd11, 16'd6});
            if (i == 4) chk("small_wrap", {last_x, last_y}, {16'd10, 16'd5});
        end
        chk("small_frm_cnt", frm_obs - f0, 2);
        cmd(8'h01);
        cmd(8'h2A); send(1, 8'h00); send(1, 8'h10);
        cmd(8'h2C);
        px(16'h1234);
        chk("partial_col_xy", {last_x, last_y}, {16'd0, 16'd0});
        chk("partial_disp", disp_on_o, 0);
        send(1, 8'h55);
        set_cs(1);
        set_cs(0);
        cmd(8'h2C);
        px(16'hABCD);
        chk("stale_drop", {last_d, last_x, last_y}, {16'hABCD, 16'd0, 16'd0});
        p0 = pxl_obs; s0 = soft_obs;
        send(1, 8'h12);
        cmd(8'h01);
        chk("soft_cmd", soft_obs - s0, 1);
        for (int i = 0; i < 6; i++) send(1, 8'($urandom));
        chk("no_pxl_after_01", pxl_obs, p0);
        cmd(8'h2C);
        px(16'h0F0F);
        chk("pxl_after_2c", pxl_obs, p0 + 1);
        for (int it = 0; it < 80; it++) begin
            n = $urandom_range(0, 99);
            if (n < 50) begin
                repeat ($urandom_range(1, 12)) send(1, 8'($urandom));
            end else if (n < 85) begin
                n = $urandom_range(0, 7);
                c = (n == 7) ? 8'($urandom) : cl[n];
                cmd(c);
                if (c == 8'h2A || c == 8'h2B) begin
                    n = $urandom_range(0, 6);
                    if (n > 4) n = 4;
                    for (int j = 0; j < n; j++) send(1, (j % 2 == 0) ? 8'h00 : 8'($urandom_range(0, 3)));
                end
            end else if (n < 93) begin
                set_cs(1);
                set_cs(0);
            end else resx_pulse();
            chk("disp_rand", disp_on_o, m_disp);
        end
        repeat (10) @(posedge clk);
        chk("pxl_left", exp_pxl.size(), 0);
        chk("cmd_left", exp_cmd.size(), 0);
        chk("soft_total", soft_obs, m_soft);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
